// File: rtl/fft_pkg.sv
// Shared widths, lane record and pair-state encoding for the bfly22_pair butterfly.
package fft_pkg;

  localparam int LANES     = 16;
  localparam int WIDTH_DEF = 14;

  function automatic int in_w(input int width);
    return width + 32'sd2;
  endfunction

  function automatic int out_w(input int width);
    return width + 32'sd3;
  endfunction

  typedef struct packed {
    logic signed [out_w(WIDTH_DEF)-1:0] re;
    logic signed [out_w(WIDTH_DEF)-1:0] im;
  } cplx_t;

  // Bit 1 = hold_a (an A block is stored), bit 0 = diff_pend (A-B waits for the port).
  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_DIFF      = 2'b01,
    ST_HOLD      = 2'b10,
    ST_HOLD_DIFF = 2'b11
  } pair_state_e;

endpackage

// File: rtl/bfly22_pair_if.sv
// Block-level input/output bundle of bfly22_pair; master drives blocks in, slave is the butterfly.
interface bfly22_pair_if #(
  parameter int WIDTH = 14
);
  import fft_pkg::*;

  localparam int IN_W  = in_w(WIDTH);
  localparam int OUT_W = out_w(WIDTH);

  logic                    in_valid;
  logic                    in_sop;
  logic signed [IN_W-1:0]  i_re [0:LANES-1];
  logic signed [IN_W-1:0]  i_im [0:LANES-1];
  logic                    out_valid;
  logic                    out_diff;
  logic signed [OUT_W-1:0] o_re [0:LANES-1];
  logic signed [OUT_W-1:0] o_im [0:LANES-1];
  logic                    pair_err;

  modport master (
    output in_valid, in_sop, i_re, i_im,
    input  out_valid, out_diff, o_re, o_im, pair_err
  );

  modport slave (
    input  in_valid, in_sop, i_re, i_im,
    output out_valid, out_diff, o_re, o_im, pair_err
  );

endinterface

// File: rtl/bfly22_pair_lane.sv
// One-lane complex add/sub for bfly22_pair. Optional BFLY22_SCALE_EN halves results with round half up.
module bfly_lane
  import fft_pkg::*;
#(
  parameter int WIDTH = 14
) (
  input  logic signed [in_w(WIDTH)-1:0]  a_re,
  input  logic signed [in_w(WIDTH)-1:0]  a_im,
  input  logic signed [in_w(WIDTH)-1:0]  b_re,
  input  logic signed [in_w(WIDTH)-1:0]  b_im,
  output logic signed [out_w(WIDTH)-1:0] sum_re,
  output logic signed [out_w(WIDTH)-1:0] sum_im,
  output logic signed [out_w(WIDTH)-1:0] dif_re,
  output logic signed [out_w(WIDTH)-1:0] dif_im
);

  localparam int IN_W  = in_w(WIDTH);
  localparam int OUT_W = out_w(WIDTH);

  function automatic logic signed [OUT_W-1:0] post(input logic signed [OUT_W-1:0] r);
`ifdef BFLY22_SCALE_EN
    // One guard bit so r+1 cannot wrap at the positive extreme.
    logic signed [OUT_W:0] rp;
    rp = {r[OUT_W-1], r} + {{OUT_W{1'b0}}, 1'b1};
    rp = rp >>> 1;
    return rp[OUT_W-1:0];
`else
    return r;
`endif
  endfunction

  logic signed [OUT_W-1:0] ax_re_s, ax_im_s, bx_re_s, bx_im_s;

  assign ax_re_s = {a_re[IN_W-1], a_re};
  assign ax_im_s = {a_im[IN_W-1], a_im};
  assign bx_re_s = {b_re[IN_W-1], b_re};
  assign bx_im_s = {b_im[IN_W-1], b_im};

  assign sum_re = post(ax_re_s + bx_re_s);
  assign sum_im = post(ax_im_s + bx_im_s);
  assign dif_re = post(ax_re_s - bx_re_s);
  assign dif_im = post(ax_im_s - bx_im_s);

endmodule

// File: rtl/bfly22_pair.sv
// Pairs consecutive 16-lane blocks A,B and emits A+B then A-B on one registered port.
// Optional scaling (BFLY22_SCALE_EN) lives in bfly_lane; latency is identical in both builds.
module bfly22_pair #(
  parameter int WIDTH = 14,
  parameter int LANES = 16
) (
  input  logic          clk,
  input  logic          rstn,
  bfly22_pair_if.slave  io
);
  import fft_pkg::*;

  localparam int IN_W  = in_w(WIDTH);
  localparam int OUT_W = out_w(WIDTH);

  typedef logic signed [IN_W-1:0]  in_t;
  typedef logic signed [OUT_W-1:0] out_t;

  pair_state_e state_q, state_d;

  in_t  a_re_q [LANES];
  in_t  a_re_d [LANES];
  in_t  a_im_q [LANES];
  in_t  a_im_d [LANES];
  out_t dif_re_q [LANES];
  out_t dif_re_d [LANES];
  out_t dif_im_q [LANES];
  out_t dif_im_d [LANES];
  out_t o_re_q [LANES];
  out_t o_re_d [LANES];
  out_t o_im_q [LANES];
  out_t o_im_d [LANES];
  out_t sum_re_s [LANES];
  out_t sum_im_s [LANES];
  out_t sub_re_s [LANES];
  out_t sub_im_s [LANES];

  logic out_valid_q, out_valid_d;
  logic out_diff_q, out_diff_d;
  logic pair_err_q, pair_err_d;
  logic hold_s, pend_s, take_a_s, take_b_s, sop_err_s;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    bfly_lane #(.WIDTH(WIDTH)) u_lane (
      .a_re   (a_re_q[g]),
      .a_im   (a_im_q[g]),
      .b_re   (io.i_re[g]),
      .b_im   (io.i_im[g]),
      .sum_re (sum_re_s[g]),
      .sum_im (sum_im_s[g]),
      .dif_re (sub_re_s[g]),
      .dif_im (sub_im_s[g])
    );
  end

  assign hold_s    = state_q[1];
  assign pend_s    = state_q[0];
  assign take_a_s  = io.in_valid && (!hold_s || io.in_sop);
  assign take_b_s  = io.in_valid && hold_s && !io.in_sop;
  assign sop_err_s = io.in_valid && hold_s && io.in_sop;

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DIFF: begin
        if (io.in_valid) state_d = ST_HOLD;
        else             state_d = ST_IDLE;
      end
      ST_HOLD, ST_HOLD_DIFF: begin
        if (io.in_valid && !io.in_sop) state_d = ST_DIFF;
        else                           state_d = ST_HOLD;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    out_valid_d = 1'b0;
    out_diff_d  = 1'b0;
    pair_err_d  = pair_err_q | sop_err_s;
    a_re_d      = a_re_q;
    a_im_d      = a_im_q;
    dif_re_d    = dif_re_q;
    dif_im_d    = dif_im_q;
    for (int i = 0; i < LANES; i++) begin
      o_re_d[i] = {OUT_W{1'b0}};
      o_im_d[i] = {OUT_W{1'b0}};
    end
    // A sum always wins the port; a pending diff cannot coexist with a B in legal traffic.
    if (take_b_s) begin
      out_valid_d = 1'b1;
      o_re_d      = sum_re_s;
      o_im_d      = sum_im_s;
      dif_re_d    = sub_re_s;
      dif_im_d    = sub_im_s;
    end else if (pend_s) begin
      out_valid_d = 1'b1;
      out_diff_d  = 1'b1;
      o_re_d      = dif_re_q;
      o_im_d      = dif_im_q;
    end else begin
      out_valid_d = 1'b0;
    end
    if (take_a_s) begin
      a_re_d = io.i_re;
      a_im_d = io.i_im;
    end else begin
      a_re_d = a_re_q;
      a_im_d = a_im_q;
    end
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      out_valid_q <= 1'b0;
      out_diff_q  <= 1'b0;
      pair_err_q  <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        a_re_q[i]   <= {IN_W{1'b0}};
        a_im_q[i]   <= {IN_W{1'b0}};
        dif_re_q[i] <= {OUT_W{1'b0}};
        dif_im_q[i] <= {OUT_W{1'b0}};
        o_re_q[i]   <= {OUT_W{1'b0}};
        o_im_q[i]   <= {OUT_W{1'b0}};
      end
    end else begin
      out_valid_q <= out_valid_d;
      out_diff_q  <= out_diff_d;
      pair_err_q  <= pair_err_d;
      a_re_q      <= a_re_d;
      a_im_q      <= a_im_d;
      dif_re_q    <= dif_re_d;
      dif_im_q    <= dif_im_d;
      o_re_q      <= o_re_d;
      o_im_q      <= o_im_d;
    end
  end

  assign io.out_valid = out_valid_q;
  assign io.out_diff  = out_diff_q;
  assign io.o_re      = o_re_q;
  assign io.o_im      = o_im_q;
  assign io.pair_err  = pair_err_q;

endmodule

// File: doc/bfly22_pair.md
Name: bfly22_pair

Overview:
- Second-stage radix-2 butterfly, directly downstream of the stage-2_1 twiddle multiplier.
- Consumes 16-lane complex blocks of width WIDTH+2, as produced by the twiddle stage.
- Pairs consecutive input blocks A and B lane-wise. Emits A+B, then A-B, on a single registered 16-lane output port, one block per cycle.

Parameters:
- WIDTH, 14: base datapath width of the upstream butterfly. Input width IN_W = WIDTH+2; output width OUT_W = WIDTH+3.
- LANES, 16: number of parallel lanes. Fixed at 16; other values are unsupported.

Ports:
- clk  in  1  clock, all state on rising edge
- rstn  in  1  asynchronous, active-high reset (1 = reset asserted)
- in_valid  in  1  input block present this cycle
- in_sop  in  1  qualifies in_valid; marks the block as an A (first of pair), forcing pair realignment
- i_re[0:15]  in  signed IN_W each  input real parts
- i_im[0:15]  in  signed IN_W each  input imaginary parts
- out_valid  out  1  output block valid
- out_diff  out  1  0 = sum block (A+B), 1 = difference block (A-B)
- o_re[0:15]  out  signed OUT_W each  output real parts
- o_im[0:15]  out  signed OUT_W each  output imaginary parts
- pair_err  out  1  sticky; set when a stored A is discarded by in_sop

Behaviour:
- Reset (asynchronous, rstn=1):
  - out_valid=0, out_diff=0, all o_re/o_im=0, pair_err=0.
  - State goes to IDLE; A and diff registers are cleared.
  - Reset mid-pair discards the stored A and any pending diff.
- State machine, two bits (hold_a, diff_pend), which are independent:
  - IDLE, hold_a=0: in_valid stores the inputs as A and sets hold_a=1.
  - HOLD, hold_a=1, in_valid, in_sop=0: the inputs are B.
    - Next cycle: o = A+B, out_valid=1, out_diff=0.
    - A-B is latched into the diff register; diff_pend=1; hold_a=0.
  - HOLD with in_valid and in_sop=1: the stored A is overwritten by the new A; pair_err is set; no output.
  - diff_pend=1: next cycle o = diff register, out_valid=1, out_diff=1; diff_pend clears.
  - in_sop in IDLE is legal: a normal A, no error.
- Timing at full rate:
  - A at t0, B at t1 → sum at t2, diff at t3. The next A may arrive at t2, its B at t3, its sum at t4.
  - Back-to-back pairs therefore give 100% output occupancy with no output collision.
  - No backpressure exists. An upstream B arriving one cycle after a previous B is impossible because A must intervene.
- Latency: sum 1 cycle after B, diff 2 cycles after B.
- Idle output: any cycle with out_valid=0 drives o_re/o_im=0 and out_diff=0.
- Arithmetic, per lane, re and im independently:
  - Sign-extend both operands to OUT_W, then add/sub.
  - Full growth, no overflow possible: range −2^(IN_W) .. 2^(IN_W)−1.
- in_valid=0 cycles between A and B are allowed; hold_a persists indefinitely.

Optional Feature:
- Macro: BFLY22_SCALE_EN
- Defined: each sum/diff result is scaled as (r + 1) >>> 1, round half up. The result is sign-extended back to OUT_W, so the port width is unchanged and magnitude bits stay within IN_W.
- Undefined: full-growth result, no rounding logic present.
- Latency is identical in both builds.

Decomposition:
- Package fft_pkg holds:
  - localparams LANES=16, IN_W/OUT_W derivation functions
  - typedef for a complex lane struct {re, im}
  - typedef enum of the hold/diff state encoding
- One natural sub-module: bfly_lane. It is one-lane combinational add/sub with the optional scale, instantiated 16× by generate. The state machine and registers stay in bfly22_pair.

Test Plan:
- Basic pair: A lane0=(100,−50), B lane0=(30,20) back-to-back → t2 o lane0=(130,−30) out_diff=0; t3 (70,−70) out_diff=1.
- Extremes, IN_W=16:
  - A re=32767, B re=32767 → sum 65534, diff 0.
  - A re=−32768, B re=32767 → sum −1, diff −65535. No wrap.
- Continuous stream of 8 blocks, in_valid held high → out_valid high for 8 consecutive cycles starting 2 cycles after the first block; sum/diff alternate.
- Gap and resync:
  - A, then 3 idle cycles, then B → sum emitted 1 cycle after B.
  - A, then in_sop block A' → pair_err=1, next B pairs with A'.
- Async reset asserted after A (before B) → outputs 0 immediately. After release, the next block is treated as A: no output until its partner arrives.
- BFLY22_SCALE_EN build:
  - A re=100, B re=30 → sum 65, diff 35.
  - A re=−2, B re=1 → sum (−1+1)>>>1=0, diff (−3+1)>>>1=−1.
